// File: rtl/interval_timer.sv
// -----------------------------------------------------------------------------
// interval_timer
//   Timing and sensor datapath for the traffic-light controller. The controller
//   selects an interval with s_IC/en_IC. This block times the interval in ticks
//   of TICK_DIV clocks and debounces the east-road car sensor. It returns four
//   status flags that drive the controller's transitions.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  asynchronous, active-high reset
//   s_IC       in   2  interval select: 00 yellow, 01 all-red, 10 N green, 11 E green
//   en_IC      in   1  interval enable; 0 freezes timing and forces all flags 0
//   car_e      in   1  raw east-road car sensor, asynchronous to clk
//   not_r      out  1  all-red interval done (combinational from registered state)
//   c_and_l    out  1  N green: car waiting east and long interval elapsed
//   en_s       out  1  yellow interval done
//   l_or_notc  out  1  E green: long elapsed, or no car east and minimum elapsed
//   car_db     out  1  debounced car sensor level (registered)
// -----------------------------------------------------------------------------
module interval_timer #(
  parameter int unsigned TICK_DIV = 50_000_000,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned T_YEL    = 3,
  parameter int unsigned T_RR     = 1,
  parameter int unsigned T_LONG   = 15,
  parameter int unsigned T_EW_MIN = 5,
  parameter int unsigned DEB_CYC  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] s_IC,
  input  logic       en_IC,
  input  logic       car_e,
  output logic       not_r,
  output logic       c_and_l,
  output logic       en_s,
  output logic       l_or_notc,
  output logic       car_db
);

  localparam int unsigned PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DEB_W = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [CNT_W-1:0] TH_YEL    = CNT_W'(T_YEL);
  localparam logic [CNT_W-1:0] TH_RR     = CNT_W'(T_RR);
  localparam logic [CNT_W-1:0] TH_LONG   = CNT_W'(T_LONG);
  localparam logic [CNT_W-1:0] TH_EW_MIN = CNT_W'(T_EW_MIN);

  // Interval encoding shared with the controller's s_IC output.
  typedef enum logic [1:0] {
    SEL_YEL = 2'b00,
    SEL_RR  = 2'b01,
    SEL_NG  = 2'b10,
    SEL_EG  = 2'b11
  } sel_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  sel_t             sel_q,   sel_d;
  logic [PRE_W-1:0] pre_q,   pre_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic             sync1_q, car_s_q;
  logic             db_q,    db_d;
  logic [DEB_W-1:0] deb_q,   deb_d;

  logic             restart_c;
  logic             tick_c;
  logic             active_c;

  // A new select while enabled means the controller changed state.
  assign restart_c = en_IC & (sel_t'(s_IC) != sel_q);
  assign tick_c    = (pre_q == PRE_LAST);
  // Flags are only meaningful once sel_q has caught up with s_IC.
  assign active_c  = en_IC & (sel_t'(s_IC) == sel_q);

  // ---------------------------------------------------------------------------
  // Interval timing next-state: restart has priority over a coincident tick
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_d = sel_q;
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (restart_c) begin
      sel_d = sel_t'(s_IC);
      pre_d = '0;
      cnt_d = '0;
    end else if (en_IC) begin
      if (tick_c) begin
        pre_d = '0;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
  end

  // Interval timing registers; reset matches the controller's initial all-red.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q <= SEL_RR;
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      sel_q <= sel_d;
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Car sensor: two-flop synchroniser, then accept a new level only after it
  // has been held for DEB_CYC consecutive cycles.
  // ---------------------------------------------------------------------------
  always_comb begin
    db_d  = db_q;
    deb_d = '0;
    if (car_s_q != db_q) begin
      if (deb_q == DEB_LAST) begin
        db_d  = car_s_q;
        deb_d = '0;
      end else begin
        deb_d = deb_q + DEB_W'(1);
      end
    end
  end

  // Synchroniser and debouncer registers; these run regardless of en_IC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      car_s_q <= 1'b0;
      db_q    <= 1'b0;
      deb_q   <= '0;
    end else begin
      sync1_q <= car_e;
      car_s_q <= sync1_q;
      db_q    <= db_d;
      deb_q   <= deb_d;
    end
  end

  assign car_db = db_q;

  // ---------------------------------------------------------------------------
  // Status flags: decoded from registered state, at most one high at a time
  // ---------------------------------------------------------------------------
  always_comb begin
    not_r     = 1'b0;
    c_and_l   = 1'b0;
    en_s      = 1'b0;
    l_or_notc = 1'b0;
    if (active_c) begin
      unique case (sel_q)
        SEL_YEL: en_s      = (cnt_q >= TH_YEL);
        SEL_RR:  not_r     = (cnt_q >= TH_RR);
        SEL_NG:  c_and_l   = db_q & (cnt_q >= TH_LONG);
        SEL_EG:  l_or_notc = (cnt_q >= TH_LONG) | (~db_q & (cnt_q >= TH_EW_MIN));
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// -----------------------------------------------------------------------------
// tb_interval_timer
//   Scoreboard bench for interval_timer. The stimulus process drives inputs
//   once per cycle, advances a behavioural model and queues the expected
//   outputs. A monitor pops and compares them on the falling edge.
// -----------------------------------------------------------------------------
module tb_interval_timer;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned T_YEL    = 3;
  localparam int unsigned T_RR     = 1;
  localparam int unsigned T_LONG   = 15;
  localparam int unsigned T_EW_MIN = 5;
  localparam int unsigned DEB_CYC  = 4;
  localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [1:0] s_IC  = 2'b01;
  logic       en_IC = 1'b0;
  logic       car_e = 1'b0;
  logic       not_r, c_and_l, en_s, l_or_notc, car_db;

  int errors = 0;
  int checks = 0;

  // Expected {not_r, c_and_l, en_s, l_or_notc, car_db}, one entry per cycle.
  logic [4:0] exp_q[$];

  // Behavioural model state.
  int unsigned m_sel;     // interval currently being timed
  int unsigned m_n;       // enabled clock edges since this interval started
  bit          m_db;      // accepted car level
  bit          m_s1, m_s2;// car_e delayed by one and two clocks
  int unsigned m_streak;  // consecutive edges the synced car level disagreed

  interval_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W),
    .T_YEL    (T_YEL),
    .T_RR     (T_RR),
    .T_LONG   (T_LONG),
    .T_EW_MIN (T_EW_MIN),
    .DEB_CYC  (DEB_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_IC      (s_IC),
    .en_IC     (en_IC),
    .car_e     (car_e),
    .not_r     (not_r),
    .c_and_l   (c_and_l),
    .en_s      (en_s),
    .l_or_notc (l_or_notc),
    .car_db    (car_db)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_sel    = 1;
    m_n      = 0;
    m_db     = 1'b0;
    m_s1     = 1'b0;
    m_s2     = 1'b0;
    m_streak = 0;
  endtask

  // Advance the model across one rising edge using the inputs held during it.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else begin
      if (en_IC) begin
        if (int'(s_IC) != m_sel) begin
          m_sel = int'(s_IC);
          m_n   = 0;
        end else begin
          m_n = m_n + 1;
        end
      end
      if (m_s2 != m_db) begin
        m_streak = m_streak + 1;
        if (m_streak == DEB_CYC) begin
          m_db     = m_s2;
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
      m_s2 = m_s1;
      m_s1 = car_e;
    end
  endtask

  // Expected outputs for the current inputs and model state.
  function automatic logic [4:0] expect_out();
    int unsigned ticks;
    logic nr, cl, es, lc;
    ticks = m_n / TICK_DIV;
    if (ticks > CNT_MAX) ticks = CNT_MAX;
    nr = 1'b0; cl = 1'b0; es = 1'b0; lc = 1'b0;
    if (en_IC && int'(s_IC) == m_sel) begin
      case (m_sel)
        0:       es = (ticks >= T_YEL);
        1:       nr = (ticks >= T_RR);
        2:       cl = m_db && (ticks >= T_LONG);
        default: lc = (ticks >= T_LONG) || (!m_db && ticks >= T_EW_MIN);
      endcase
    end
    return {nr, cl, es, lc, m_db};
  endfunction

  // One cycle of stimulus: drive just after the edge, queue the expectation.
  task automatic apply(input logic r, input logic [1:0] s, input logic e, input logic c);
    logic rise;
    @(posedge clk);
    #1;
    model_edge();
    rise  = r && !rst;
    rst   = r;
    s_IC  = s;
    en_IC = e;
    car_e = c;
    if (r) model_reset();
    if (rise) begin
      #1;
      checks = checks + 1;
      if ({not_r, c_and_l, en_s, l_or_notc, car_db} !== 5'b0) begin
        errors = errors + 1;
        $display("FAIL async_reset: got %b want 00000 at %0t",
                 {not_r, c_and_l, en_s, l_or_notc, car_db}, $time);
      end
    end
    exp_q.push_back(expect_out());
  endtask

  // Monitor: compare every cycle's outputs against the queued expectation.
  initial begin
    logic [4:0] want, got;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        got  = {not_r, c_and_l, en_s, l_or_notc, car_db};
        checks = checks + 1;
        if (got !== want) begin
          errors = errors + 1;
          $display("FAIL flags {not_r,c_and_l,en_s,l_or_notc,car_db}: got %b want %b at %0t",
                   got, want, $time);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  r_sel;
    logic        r_en, r_car, r_rst;
    int unsigned sel_left, en_left, car_left, rst_left;

    model_reset();

    // Reset, then all-red timing from reset state.
    repeat (3)  apply(1'b1, 2'b01, 1'b1, 1'b0);
    repeat (12) apply(1'b0, 2'b01, 1'b1, 1'b0);
    // Yellow interval.
    repeat (20) apply(1'b0, 2'b00, 1'b1, 1'b0);
    // N green: no car, then a car arrives after the long interval.
    for (int i = 0; i < 110; i++) apply(1'b0, 2'b10, 1'b1, (i >= 100));
    // E green with car present, then with no car.
    repeat (70) apply(1'b0, 2'b11, 1'b1, 1'b1);
    repeat (10) apply(1'b0, 2'b01, 1'b1, 1'b0);
    repeat (30) apply(1'b0, 2'b11, 1'b1, 1'b0);
    // Sensor glitch then a held pulse.
    repeat (2)  apply(1'b0, 2'b10, 1'b1, 1'b1);
    repeat (10) apply(1'b0, 2'b10, 1'b1, 1'b0);
    repeat (10) apply(1'b0, 2'b10, 1'b1, 1'b1);
    repeat (10) apply(1'b0, 2'b10, 1'b1, 1'b0);
    // Yellow with an enable gap.
    repeat (5)  apply(1'b0, 2'b00, 1'b1, 1'b0);
    repeat (20) apply(1'b0, 2'b00, 1'b0, 1'b0);
    repeat (20) apply(1'b0, 2'b00, 1'b1, 1'b0);
    // Reset in the middle of E green, then resume.
    repeat (30) apply(1'b0, 2'b11, 1'b1, 1'b0);
    repeat (2)  apply(1'b1, 2'b11, 1'b1, 1'b0);
    repeat (30) apply(1'b0, 2'b11, 1'b1, 1'b0);
    // Long hold so the interval counter saturates.
    repeat (1100) apply(1'b0, 2'b10, 1'b1, 1'b1);

    // Randomised traffic.
    r_sel = 2'b01; r_en = 1'b1; r_car = 1'b0; r_rst = 1'b0;
    sel_left = 0; en_left = 0; car_left = 0; rst_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if (sel_left == 0) begin
        r_sel    = 2'($urandom_range(0, 3));
        sel_left = $urandom_range(1, 90);
      end
      if (en_left == 0) begin
        r_en    = ($urandom_range(0, 9) != 0);
        en_left = r_en ? $urandom_range(10, 120) : $urandom_range(1, 25);
      end
      if (car_left == 0) begin
        r_car    = ~r_car;
        car_left = $urandom_range(1, 12);
      end
      if (rst_left == 0) begin
        r_rst    = ($urandom_range(0, 700) == 0);
        rst_left = r_rst ? $urandom_range(1, 3) : 1;
      end
      apply(r_rst, r_sel, r_en, r_car);
      sel_left = sel_left - 1;
      en_left  = en_left - 1;
      car_left = car_left - 1;
      rst_left = rst_left - 1;
    end

    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
